// File: rtl/cosim_sync_scoreboard.sv
// In-order pairwise comparator for a gold result stream and a DUT result stream.
// Each stream is buffered in its own FIFO; heads are popped and compared together.
module cosim_sync_scoreboard #(
    parameter int W           = 7,
    parameter int DEPTH       = 4,
    parameter int CW          = 16,
    parameter int TIMEOUT     = 64,
    parameter int HALT_ON_ERR = 0
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          gold_valid,
    output logic          gold_ready,
    input  logic [W-1:0]  gold_data,
    input  logic          dut_valid,
    output logic          dut_ready,
    input  logic [W-1:0]  dut_data,
    output logic          cmp_valid,
    output logic          cmp_match,
    output logic [CW-1:0] match_count,
    output logic [CW-1:0] mismatch_count,
    output logic          err_flag,
    output logic [W-1:0]  first_err_gold,
    output logic [W-1:0]  first_err_dut,
    output logic          timeout_flag,
    output logic          halted
);

    localparam int          AW         = $clog2(DEPTH);
    localparam logic [15:0] TO_LIMIT   = 16'(TIMEOUT);
    localparam bit          HALT_EN    = (HALT_ON_ERR != 0);

    typedef enum logic {RUN, HALTED} state_t;

    state_t state, state_next;

    logic          started;
    logic [W-1:0]  gold_mem [DEPTH];
    logic [W-1:0]  dut_mem  [DEPTH];
    logic [AW:0]   gold_wr, gold_rd, dut_wr, dut_rd;
    logic          gold_empty, gold_full, dut_empty, dut_full;
    logic          gold_push, dut_push, do_cmp, is_match, one_pending;
    logic [W-1:0]  gold_head, dut_head;
    logic [15:0]   to_cnt;

    assign gold_empty = (gold_wr == gold_rd);
    assign dut_empty  = (dut_wr == dut_rd);
    assign gold_full  = (gold_wr[AW-1:0] == gold_rd[AW-1:0]) && (gold_wr[AW] != gold_rd[AW]);
    assign dut_full   = (dut_wr[AW-1:0] == dut_rd[AW-1:0]) && (dut_wr[AW] != dut_rd[AW]);

    // Readies stay low until the first edge after reset releases.
    assign gold_ready = started && !gold_full && (state == RUN);
    assign dut_ready  = started && !dut_full && (state == RUN);
    assign gold_push  = gold_valid && gold_ready;
    assign dut_push   = dut_valid && dut_ready;

    assign gold_head   = gold_mem[gold_rd[AW-1:0]];
    assign dut_head    = dut_mem[dut_rd[AW-1:0]];
    assign do_cmp      = !gold_empty && !dut_empty && (state == RUN);
    assign is_match    = (gold_head == dut_head);
    assign one_pending = (gold_empty != dut_empty) && (state == RUN);
    assign halted      = (state == HALTED);

    always_ff @(posedge CLK) begin
        if (gold_push) gold_mem[gold_wr[AW-1:0]] <= gold_data;
        if (dut_push)  dut_mem[dut_wr[AW-1:0]]   <= dut_data;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            started <= 1'b0;
            gold_wr <= '0;
            gold_rd <= '0;
            dut_wr  <= '0;
            dut_rd  <= '0;
        end else begin
            started <= 1'b1;
            if (gold_push) gold_wr <= gold_wr + 1'b1;
            if (dut_push)  dut_wr  <= dut_wr + 1'b1;
            if (do_cmp) begin
                gold_rd <= gold_rd + 1'b1;
                dut_rd  <= dut_rd + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state <= RUN;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (state == RUN && do_cmp && !is_match && HALT_EN)
            state_next = HALTED;
    end

    // Counters saturate rather than wrap so a long run never reads back as clean.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cmp_valid      <= 1'b0;
            cmp_match      <= 1'b0;
            match_count    <= '0;
            mismatch_count <= '0;
            err_flag       <= 1'b0;
            first_err_gold <= '0;
            first_err_dut  <= '0;
        end else begin
            cmp_valid <= do_cmp;
            cmp_match <= do_cmp && is_match;
            if (do_cmp) begin
                if (is_match) begin
                    if (match_count != '1) match_count <= match_count + 1'b1;
                end else begin
                    if (mismatch_count != '1) mismatch_count <= mismatch_count + 1'b1;
                    if (!err_flag) begin
                        err_flag       <= 1'b1;
                        first_err_gold <= gold_head;
                        first_err_dut  <= dut_head;
                    end
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            to_cnt       <= '0;
            timeout_flag <= 1'b0;
        end else if (do_cmp || (gold_empty && dut_empty)) begin
            to_cnt <= '0;
        end else if (one_pending && to_cnt != TO_LIMIT) begin
            to_cnt <= to_cnt + 16'd1;
            if (to_cnt + 16'd1 == TO_LIMIT) timeout_flag <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cosim_sync_scoreboard.sv
// Bench for cosim_sync_scoreboard: a free-running and a halt-on-error instance
// share the stimulus; a queue scoreboard predicts every compare result.
module tb_cosim_sync_scoreboard;

    localparam int W  = 7;
    localparam int CW = 16;

    logic          CLK = 1'b0;
    logic          RESET = 1'b1;
    logic          gold_valid = 1'b0;
    logic [W-1:0]  gold_data = '0;
    logic          dut_valid = 1'b0;
    logic [W-1:0]  dut_data = '0;
    logic          sel_halt = 1'b0;

    logic          m_gold_ready, m_dut_ready, m_cmp_valid, m_cmp_match, m_err, m_to, m_halted;
    logic [CW-1:0] m_match, m_mis;
    logic [W-1:0]  m_feg, m_fed;
    logic          h_gold_ready, h_dut_ready, h_cmp_valid, h_cmp_match, h_err, h_to, h_halted;
    logic [CW-1:0] h_match, h_mis;
    logic [W-1:0]  h_feg, h_fed;

    logic          gold_ready, dut_ready, cmp_valid, cmp_match, err_flag, timeout_flag, halted;
    logic [CW-1:0] match_count, mismatch_count;
    logic [W-1:0]  first_err_gold, first_err_dut;

    assign gold_ready     = sel_halt ? h_gold_ready : m_gold_ready;
    assign dut_ready      = sel_halt ? h_dut_ready  : m_dut_ready;
    assign cmp_valid      = sel_halt ? h_cmp_valid  : m_cmp_valid;
    assign cmp_match      = sel_halt ? h_cmp_match  : m_cmp_match;
    assign match_count    = sel_halt ? h_match      : m_match;
    assign mismatch_count = sel_halt ? h_mis        : m_mis;
    assign err_flag       = sel_halt ? h_err        : m_err;
    assign first_err_gold = sel_halt ? h_feg        : m_feg;
    assign first_err_dut  = sel_halt ? h_fed        : m_fed;
    assign timeout_flag   = sel_halt ? h_to         : m_to;
    assign halted         = sel_halt ? h_halted     : m_halted;

    cosim_sync_scoreboard #(.W(W), .DEPTH(4), .CW(CW), .TIMEOUT(8), .HALT_ON_ERR(0)) u_main (
        .CLK(CLK), .RESET(RESET),
        .gold_valid(gold_valid), .gold_ready(m_gold_ready), .gold_data(gold_data),
        .dut_valid(dut_valid), .dut_ready(m_dut_ready), .dut_data(dut_data),
        .cmp_valid(m_cmp_valid), .cmp_match(m_cmp_match),
        .match_count(m_match), .mismatch_count(m_mis), .err_flag(m_err),
        .first_err_gold(m_feg), .first_err_dut(m_fed),
        .timeout_flag(m_to), .halted(m_halted)
    );

    cosim_sync_scoreboard #(.W(W), .DEPTH(4), .CW(CW), .TIMEOUT(8), .HALT_ON_ERR(1)) u_halt (
        .CLK(CLK), .RESET(RESET),
        .gold_valid(gold_valid), .gold_ready(h_gold_ready), .gold_data(gold_data),
        .dut_valid(dut_valid), .dut_ready(h_dut_ready), .dut_data(dut_data),
        .cmp_valid(h_cmp_valid), .cmp_match(h_cmp_match),
        .match_count(h_match), .mismatch_count(h_mis), .err_flag(h_err),
        .first_err_gold(h_feg), .first_err_dut(h_fed),
        .timeout_flag(h_to), .halted(h_halted)
    );

    always #5 CLK = ~CLK;

    int compared = 0;
    int mismatched = 0;
    int model_match = 0;
    int model_mis = 0;
    logic [W-1:0] gold_q [$];
    logic [W-1:0] dut_q  [$];
    logic [W-1:0] gold_vals [16];
    logic [W-1:0] dut_vals  [16];

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Every compare the selected instance reports must match the next queued pair.
    always @(negedge CLK) begin
        if (!RESET && cmp_valid) begin
            if (gold_q.size() == 0 || dut_q.size() == 0) begin
                checkOutput("cmp_unexpected", 32'd1, 32'd0);
            end else begin
                logic [W-1:0] g, d;
                g = gold_q.pop_front();
                d = dut_q.pop_front();
                checkOutput("cmp_match", 32'(cmp_match), 32'(g == d));
                if (g == d) model_match++;
                else        model_mis++;
            end
        end
    end

    task automatic apply_reset();
        @(negedge CLK);
        #2 RESET = 1'b1;
        gold_valid = 1'b0;
        dut_valid  = 1'b0;
        gold_q.delete();
        dut_q.delete();
        model_match = 0;
        model_mis   = 0;
        #1;
        checkOutput("rst_gold_ready", 32'(gold_ready), 32'd0);
        checkOutput("rst_dut_ready", 32'(dut_ready), 32'd0);
        @(negedge CLK);
        RESET = 1'b0;
        #1 checkOutput("rst_ready_held", 32'(gold_ready), 32'd0);
        @(posedge CLK);
        #1;
        checkOutput("post_rst_gold_ready", 32'(gold_ready), 32'd1);
        checkOutput("post_rst_dut_ready", 32'(dut_ready), 32'd1);
        checkOutput("post_rst_match", 32'(match_count), 32'd0);
        checkOutput("post_rst_err", 32'(err_flag), 32'd0);
        checkOutput("post_rst_halted", 32'(halted), 32'd0);
    endtask

    task automatic applyStimulus(input int ng, input int nd, input int budget, input bit must_finish);
        int gi = 0;
        int di = 0;
        int cyc = 0;
        bit g_acc, d_acc;
        while ((gi < ng || di < nd) && cyc < budget) begin
            @(negedge CLK);
            gold_valid = (gi < ng);
            if (gi < ng) gold_data = gold_vals[gi];
            dut_valid = (di < nd);
            if (di < nd) dut_data = dut_vals[di];
            #1;
            g_acc = gold_valid && gold_ready;
            d_acc = dut_valid && dut_ready;
            @(posedge CLK);
            if (g_acc) begin gold_q.push_back(gold_data); gi++; end
            if (d_acc) begin dut_q.push_back(dut_data); di++; end
            cyc++;
        end
        if (must_finish) checkOutput("stim_done", 32'(gi + di), 32'(ng + nd));
        @(negedge CLK);
        gold_valid = 1'b0;
        dut_valid  = 1'b0;
    endtask

    task automatic drain();
        int cyc = 0;
        while (gold_q.size() != 0 && dut_q.size() != 0 && cyc < 20) begin
            @(negedge CLK);
            cyc++;
        end
        checkOutput("drain_done", 32'(cyc < 20), 32'd1);
        @(negedge CLK);
    endtask

    task automatic load_mismatch_case();
        for (int i = 0; i < 5; i++) begin
            gold_vals[i] = 7'(i + 1);
            dut_vals[i]  = 7'(i + 1);
        end
        dut_vals[2] = 7'd9;
    endtask

    initial begin
        $display("[TB] start");

        // Clean stream of ten identical pairs.
        sel_halt = 1'b0;
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            gold_vals[i] = 7'(i + 1);
            dut_vals[i]  = 7'(i + 1);
        end
        applyStimulus(10, 10, 40, 1'b1);
        drain();
        checkOutput("t1_pulses", 32'(model_match + model_mis), 32'd10);
        checkOutput("t1_match_count", 32'(match_count), 32'd10);
        checkOutput("t1_mismatch_count", 32'(mismatch_count), 32'd0);
        checkOutput("t1_err", 32'(err_flag), 32'd0);
        checkOutput("t1_timeout", 32'(timeout_flag), 32'd0);

        // One corrupted DUT value in the middle.
        apply_reset();
        load_mismatch_case();
        applyStimulus(5, 5, 30, 1'b1);
        drain();
        checkOutput("t2_match_count", 32'(match_count), 32'd4);
        checkOutput("t2_mismatch_count", 32'(mismatch_count), 32'd1);
        checkOutput("t2_err", 32'(err_flag), 32'd1);
        checkOutput("t2_first_gold", 32'(first_err_gold), 32'd3);
        checkOutput("t2_first_dut", 32'(first_err_dut), 32'd9);

        // Async reset with three gold entries buffered and counters non-zero.
        gold_vals[0] = 7'd1; gold_vals[1] = 7'd2; gold_vals[2] = 7'd3;
        applyStimulus(3, 0, 10, 1'b1);
        checkOutput("t3_ready_3", 32'(gold_ready), 32'd1);
        @(negedge CLK);
        #2 RESET = 1'b1;
        #1;
        checkOutput("t3_match_clr", 32'(match_count), 32'd0);
        checkOutput("t3_mis_clr", 32'(mismatch_count), 32'd0);
        checkOutput("t3_err_clr", 32'(err_flag), 32'd0);
        checkOutput("t3_feg_clr", 32'(first_err_gold), 32'd0);
        checkOutput("t3_fed_clr", 32'(first_err_dut), 32'd0);
        checkOutput("t3_ready_clr", 32'(gold_ready), 32'd0);
        gold_q.delete();
        dut_q.delete();
        model_match = 0;
        model_mis   = 0;
        @(negedge CLK);
        RESET = 1'b0;
        @(posedge CLK);
        gold_vals[0] = 7'd5;
        dut_vals[0]  = 7'd5;
        applyStimulus(1, 1, 10, 1'b1);
        drain();
        checkOutput("t3_first_pair_match", 32'(match_count), 32'd1);
        checkOutput("t3_first_pair_mis", 32'(mismatch_count), 32'd0);
        checkOutput("t3_pulses", 32'(model_match), 32'd1);

        // Gold fills its FIFO while the DUT side is idle.
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            gold_vals[i] = 7'(i + 11);
            dut_vals[i]  = 7'(i + 11);
        end
        applyStimulus(4, 0, 20, 1'b1);
        checkOutput("t4_gold_full", 32'(gold_ready), 32'd0);
        checkOutput("t4_dut_ready", 32'(dut_ready), 32'd1);
        applyStimulus(0, 4, 20, 1'b1);
        drain();
        checkOutput("t4_match_count", 32'(match_count), 32'd4);
        checkOutput("t4_gold_ready_back", 32'(gold_ready), 32'd1);

        // A lone gold entry pends for TIMEOUT cycles.
        apply_reset();
        gold_vals[0] = 7'd7;
        dut_vals[0]  = 7'd7;
        applyStimulus(1, 0, 10, 1'b1);
        @(posedge CLK);
        #1 checkOutput("t5_to_after_accept", 32'(timeout_flag), 32'd0);
        repeat (6) @(posedge CLK);
        #1 checkOutput("t5_to_cycle7", 32'(timeout_flag), 32'd0);
        @(posedge CLK);
        #1 checkOutput("t5_to_cycle8", 32'(timeout_flag), 32'd1);
        applyStimulus(0, 1, 10, 1'b1);
        drain();
        checkOutput("t5_match_count", 32'(match_count), 32'd1);
        checkOutput("t5_to_sticky", 32'(timeout_flag), 32'd1);

        // Halt-on-error instance stops after the first mismatch.
        sel_halt = 1'b1;
        apply_reset();
        load_mismatch_case();
        applyStimulus(5, 5, 15, 1'b0);
        repeat (3) @(negedge CLK);
        checkOutput("t6_halted", 32'(halted), 32'd1);
        checkOutput("t6_gold_ready", 32'(gold_ready), 32'd0);
        checkOutput("t6_dut_ready", 32'(dut_ready), 32'd0);
        checkOutput("t6_match_count", 32'(match_count), 32'd2);
        checkOutput("t6_mismatch_count", 32'(mismatch_count), 32'd1);
        checkOutput("t6_first_gold", 32'(first_err_gold), 32'd3);
        checkOutput("t6_first_dut", 32'(first_err_dut), 32'd9);
        checkOutput("t6_pulses", 32'(model_match + model_mis), 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
